// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad safe: FSM state codes, key codes and keypad map.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    // One nibble per key, index = row*3 + col, index 0 in the LSBs.
    // Rows: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
    localparam logic [47:0] KEY_MAP = 48'hB0A987654321;

    // Translate a (row, col) position into its key code.
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] idx;
        idx = 4'(row_idx) * 4'd3 + 4'(col_idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_lock_ctrl_decoder.sv
// Keypad scanner front end: registers row/col pins and emits one key event per clean press.
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_key_valid,
    output logic [3:0] o_key_code
);

    logic [3:0] r_row;
    logic [2:0] r_col;
    logic       r_prev_idle;
    logic       w_press;
    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;

    // Locate the single active row/col and qualify a press edge from an idle keypad.
    always_comb begin
        w_row_idx = '0;
        w_col_idx = '0;
        for (int i = 0; i < int'(KP_ROWS); i++) begin
            if (r_row[i]) w_row_idx = 2'(i);
        end
        for (int j = 0; j < int'(KP_COLS); j++) begin
            if (r_col[j]) w_col_idx = 2'(j);
        end
        w_press = $onehot(r_row) && $onehot(r_col) && r_prev_idle;
    end

    // Pin capture, idle history and registered key event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_prev_idle <= 1'b1;
            o_key_valid <= 1'b0;
            o_key_code  <= KEY_NONE;
        end else begin
            r_row       <= i_row;
            r_col       <= i_col;
            r_prev_idle <= (r_row == '0) && (r_col == '0);
            o_key_valid <= w_press;
            o_key_code  <= w_press ? key_lookup(w_row_idx, w_col_idx) : KEY_NONE;
        end
    end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad safe controller: password entry, check, lockout after repeated failures, reprogramming.
module keypad_lock_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned         PW_LEN         = 6,
    parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 24'h123456,
    parameter int unsigned         MAX_FAIL       = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row,
    input  logic [2:0]        col,
    input  logic              initialize,
    output logic [2:0]        state,
    output logic [PW_LEN-1:0] passward_led,
    output logic              unlocked,
    output logic              alarm,
    output logic [3:0]        fail_count
);

    localparam int unsigned PW_W  = 4 * PW_LEN;
    localparam int unsigned CNT_W = $clog2(PW_LEN + 1);
    localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(PW_LEN);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [PW_W-1:0]  r_entry, w_entry_nxt, w_entry_wr;
    logic [PW_W-1:0]  r_stored, w_stored_nxt;
    logic [3:0]       r_fail, w_fail_nxt, w_fail_inc;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;

    logic       w_key_valid;
    logic [3:0] w_key_code;
    logic       w_is_digit, w_is_star, w_is_hash, w_room;

    keypad_decoder u_decoder (
        .clk         (clk),
        .reset       (reset),
        .i_row       (row),
        .i_col       (col),
        .o_key_valid (w_key_valid),
        .o_key_code  (w_key_code)
    );

    assign w_is_digit = w_key_valid && is_digit(w_key_code);
    assign w_is_star  = w_key_valid && (w_key_code == KEY_STAR);
    assign w_is_hash  = w_key_valid && (w_key_code == KEY_HASH);
    assign w_room     = r_count < CNT_FULL;
    assign w_fail_inc = (r_fail == 4'hF) ? 4'hF : r_fail + 4'd1;

    // Entry buffer with the incoming digit placed in slot r_count (slot 0 in the MSBs).
    always_comb begin
        w_entry_wr = r_entry;
        for (int i = 0; i < int'(PW_LEN); i++) begin
            if (r_count == CNT_W'(i)) w_entry_wr[4*(int'(PW_LEN)-1-i) +: 4] = w_key_code;
        end
    end

    // Next-state and datapath update for the safe FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_entry_nxt  = r_entry;
        w_stored_nxt = r_stored;
        w_fail_nxt   = r_fail;
        w_timer_nxt  = r_timer;
        case (r_state)
            ST_LOCKED: begin
                if (w_is_digit && w_room) begin
                    w_entry_nxt = w_entry_wr;
                    w_count_nxt = r_count + CNT_W'(1);
                end else if (w_is_star) begin
                    w_count_nxt = '0;
                end else if (w_is_hash) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_count_nxt = '0;
                if ((r_count == CNT_FULL) && (r_entry == r_stored)) begin
                    w_state_nxt = ST_OPEN;
                    w_fail_nxt  = '0;
                end else begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc >= FAIL_LIMIT) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_timer_nxt = TMR_LOAD;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_OPEN: begin
                if (w_is_star) begin
                    w_state_nxt = ST_LOCKED;
                end else if (initialize && !w_key_valid) begin
                    w_state_nxt = ST_PROGRAM;
                    w_count_nxt = '0;
                end
            end
            ST_PROGRAM: begin
                if (w_is_digit && w_room) begin
                    w_entry_nxt = w_entry_wr;
                    w_count_nxt = r_count + CNT_W'(1);
                end else if (w_is_hash || w_is_star) begin
                    if (w_is_hash && (r_count == CNT_FULL)) w_stored_nxt = r_entry;
                    w_state_nxt = ST_OPEN;
                    w_count_nxt = '0;
                end
            end
            ST_LOCKOUT: begin
                w_count_nxt = '0;
                if (r_timer == '0) begin
                    w_state_nxt = ST_LOCKED;
                    w_fail_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOCKED;
                w_count_nxt = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_LOCKED;
            r_count  <= '0;
            r_entry  <= '0;
            r_stored <= DEFAULT_PW;
            r_fail   <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_entry  <= w_entry_nxt;
            r_stored <= w_stored_nxt;
            r_fail   <= w_fail_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        for (int i = 0; i < int'(PW_LEN); i++) begin
            passward_led[i] = r_count > CNT_W'(i);
        end
    end

    assign state      = 3'(r_state);
    assign unlocked   = (r_state == ST_OPEN) || (r_state == ST_PROGRAM);
    assign alarm      = (r_state == ST_LOCKOUT);
    assign fail_count = r_fail;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboard bench for keypad_lock_ctrl: key-level reference model predicts each output change.
module tb_keypad_lock_ctrl;

    localparam int PW = 6;
    localparam int MF = 3;
    localparam int LC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row = '0;
    logic [2:0] col = '0;
    logic       initialize = 1'b0;
    logic [2:0] state;
    logic [PW-1:0] passward_led;
    logic       unlocked, alarm;
    logic [3:0] fail_count;

    always #5 clk = ~clk;

    keypad_lock_ctrl #(
        .PW_LEN(PW), .DEFAULT_PW(24'h123456), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .initialize(initialize),
        .state(state), .passward_led(passward_led), .unlocked(unlocked),
        .alarm(alarm), .fail_count(fail_count)
    );

    typedef struct { int st; int cnt; int fl; int gap; } snap_t;

    snap_t exp_q[$];
    snap_t last_push;
    int    n_chk = 0, n_fail = 0, cyc = 0;
    bit    mon_en = 0;
    bit    last_lockout = 0;

    // Reference model: state code, digit count, fail counter, entry and stored password.
    int m_st, m_cnt, m_fail;
    int m_entry[PW];
    int m_stored[PW];

    always @(posedge clk) begin
        cyc++;
        if (cyc > 90000) begin
            $display("FAIL watchdog cycles=%0d queue=%0d", cyc, exp_q.size());
            $fatal(1, "watchdog expired");
        end
    end

    function automatic void push(int gap);
        snap_t s;
        s.st = m_st; s.cnt = m_cnt; s.fl = m_fail; s.gap = gap;
        if (s.st != last_push.st || s.cnt != last_push.cnt || s.fl != last_push.fl) begin
            exp_q.push_back(s);
            last_push = s;
        end
    endfunction

    function automatic void model_reset();
        m_st = 0; m_cnt = 0; m_fail = 0;
        for (int i = 0; i < PW; i++) m_stored[i] = i + 1;
        push(0);
    endfunction

    // Apply one key event at transaction level; returns 1 when it triggers a lockout.
    function automatic bit model_key(int k);
        bit pass;
        bit lk = 0;
        case (m_st)
            0: begin
                if (k <= 9) begin
                    if (m_cnt < PW) begin m_entry[m_cnt] = k; m_cnt++; push(0); end
                end else if (k == 10) begin
                    m_cnt = 0; push(0);
                end else begin
                    m_st = 1; push(0);
                    pass = (m_cnt == PW);
                    for (int i = 0; i < PW; i++) if (m_entry[i] != m_stored[i]) pass = 0;
                    m_cnt = 0;
                    if (pass) begin
                        m_st = 2; m_fail = 0; push(1);
                    end else begin
                        m_fail = (m_fail >= 15) ? 15 : m_fail + 1;
                        if (m_fail >= MF) begin
                            m_st = 4; push(1);
                            m_st = 0; m_fail = 0; push(LC);
                            lk = 1;
                        end else begin
                            m_st = 0; push(1);
                        end
                    end
                end
            end
            2: if (k == 10) begin m_st = 0; push(0); end
            3: begin
                if (k <= 9) begin
                    if (m_cnt < PW) begin m_entry[m_cnt] = k; m_cnt++; push(0); end
                end else begin
                    if (k == 11 && m_cnt == PW)
                        for (int i = 0; i < PW; i++) m_stored[i] = m_entry[i];
                    m_st = 2; m_cnt = 0; push(0);
                end
            end
            default: ;
        endcase
        return lk;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press key k for 'hold' cycles then release for 'rel' cycles.
    task automatic press(input int k, input int hold, input int rel, input bit modeled = 1'b1);
        int r, c;
        if (k == 0) begin r = 3; c = 1; end
        else if (k == 10) begin r = 3; c = 0; end
        else if (k == 11) begin r = 3; c = 2; end
        else begin r = (k - 1) / 3; c = (k - 1) % 3; end
        last_lockout = modeled ? model_key(k) : 1'b0;
        @(negedge clk);
        row = 4'(1 << r); col = 3'(1 << c);
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        row = '0; col = '0;
        repeat (rel - 1) @(negedge clk);
    endtask

    task automatic raw(input logic [3:0] rw, input logic [2:0] cl, input int hold);
        @(negedge clk);
        row = rw; col = cl;
        repeat (hold) @(negedge clk);
        row = '0; col = '0;
        idle(2);
    endtask

    // Enter the n-digit decimal number val (MSD first), optionally followed by '#'.
    task automatic keys(input int val, input int n, input bit hash);
        int div;
        for (int i = n - 1; i >= 0; i--) begin
            div = 1;
            for (int j = 0; j < i; j++) div *= 10;
            press((val / div) % 10, 2, 2);
        end
        if (hash) press(11, 2, 2);
    endtask

    task automatic pulse_init();
        idle(2);
        if (m_st == 2) begin m_st = 3; m_cnt = 0; push(0); end
        @(negedge clk); initialize = 1'b1;
        @(negedge clk); initialize = 1'b0;
    endtask

    task automatic do_reset();
        idle(2);
        model_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitor: every change of the output vector is matched against the next expected snapshot.
    logic [15:0] last_obs;
    int          last_cyc;
    always @(negedge clk) begin
        logic [15:0] cur;
        logic [PW-1:0] e_led;
        int gap;
        snap_t e;
        cur = {state, passward_led, unlocked, alarm, fail_count, 1'b0};
        if (mon_en && cur !== last_obs) begin
            gap = cyc - last_cyc;
            last_cyc = cyc;
            last_obs = cur;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d state=%0d led=%b unl=%b alarm=%b fail=%0d",
                         cyc, state, passward_led, unlocked, alarm, fail_count);
            end else begin
                e = exp_q.pop_front();
                e_led = PW'((1 << e.cnt) - 1);
                if (state !== 3'(e.st) || passward_led !== e_led || unlocked !== (e.st == 2 || e.st == 3)
                    || alarm !== (e.st == 4) || fail_count !== 4'(e.fl) || (e.gap > 0 && gap != e.gap)) begin
                    n_fail++;
                    $display("FAIL output_change cyc=%0d got st=%0d led=%b unl=%b al=%b fail=%0d gap=%0d expected st=%0d led=%b fail=%0d gap=%0d",
                             cyc, state, passward_led, unlocked, alarm, fail_count, gap,
                             e.st, e_led, e.fl, e.gap);
                end
            end
        end
    end

    initial begin
        int k, r;
        last_push.st = -1; last_push.cnt = -1; last_push.fl = -1; last_push.gap = 0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_led", int'(passward_led), 0);
        chk("reset_unlocked", int'(unlocked), 0);
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_fail", int'(fail_count), 0);
        model_reset();
        exp_q.delete();
        last_obs = {state, passward_led, unlocked, alarm, fail_count, 1'b0};
        last_cyc = cyc;
        mon_en = 1;

        // Default unlock and relock.
        keys(123456, 6, 1);
        press(10, 2, 2);

        // Three wrong entries -> lockout; a key pressed during lockout is ignored.
        keys(0, 6, 1);
        keys(0, 6, 1);
        keys(0, 6, 0);
        press(11, 2, 2);
        press(5, 1, 2, 1'b0);
        idle(LC + 6);

        // Short entry, clear, and digit overflow.
        keys(123, 3, 1);
        keys(9, 1, 0);
        press(10, 2, 2);
        keys(1234567, 7, 0);
        press(10, 2, 2);

        // Reprogramming, relock, old password rejected, short-entry abort.
        keys(123456, 6, 1);
        pulse_init();
        keys(654321, 6, 1);
        press(10, 2, 2);
        keys(654321, 6, 1);
        press(10, 2, 2);
        keys(123456, 6, 1);
        keys(654321, 6, 1);
        pulse_init();
        keys(1111, 4, 1);
        press(10, 2, 2);
        keys(654321, 6, 1);
        press(10, 2, 2);

        // Decoder: two rows at once gives nothing; a long hold enters one digit.
        raw(4'b0011, 3'b001, 3);
        press(5, 20, 2);
        press(10, 2, 2);

        // Reset in the middle of programming restores the default password.
        keys(654321, 6, 1);
        pulse_init();
        keys(987, 3, 0);
        do_reset();
        keys(123456, 6, 1);
        press(10, 2, 2);

        // Randomised key traffic.
        for (int i = 0; i < 250; i++) begin
            if (m_st == 2 && $urandom_range(0, 2) == 0) pulse_init();
            r = $urandom_range(0, 15);
            if (r == 0) begin
                for (int j = 0; j < PW; j++) press(m_stored[j], 2, 2);
                k = 11;
            end else if (r < 3) k = 10;
            else if (r < 5) k = 11;
            else k = $urandom_range(0, 9);
            press(k, $urandom_range(1, 4), $urandom_range(1, 3));
            if (last_lockout) idle(LC + 6);
        end

        idle(LC + 20);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expected got=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
